// File: rtl/ascon_pack.sv
// Shared types and round-index constants for the ASCON-128 control path.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    WAIT_FIN,
    FINAL
  } type_fsm_state;

  localparam logic [3:0] ROUND_A_START = 4'd0;
  localparam logic [3:0] ROUND_B_START = 4'd6;
  localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/ascon_round_counter.sv
// Round index counter: load has priority over increment and it saturates at the last round.
module ascon_round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] round_o
);

  logic [3:0] round_d;
  logic [3:0] round_q;

  always_comb begin
    round_d = round_q;
    if (load_i) begin
      round_d = load_val_i;
    end else if (en_i && (round_q != ROUND_LAST)) begin
      round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      round_q <= ROUND_A_START;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o = round_q;

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption control FSM: sequences init, one AD block, NB_PT_BLOCKS
// plaintext blocks and finalisation over a one-round-per-cycle permutation datapath.
module ascon_fsm
  import ascon_pack::*;
#(
  parameter  int NB_PT_BLOCKS = 4,
  localparam int IDX_W        = $clog2(NB_PT_BLOCKS + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             init_state_o,
  output logic             en_reg_state_o,
  output logic [3:0]       round_o,
  output logic             en_xor_data_begin_o,
  output logic             en_xor_key_begin_o,
  output logic             en_xor_key_end_o,
  output logic             en_xor_lsb_end_o,
  output logic             en_cipher_o,
  output logic             en_tag_o,
  output logic [IDX_W-1:0] block_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] LAST_PT_IDX = IDX_W'(NB_PT_BLOCKS - 1);

  type_fsm_state    state_d, state_q;
  logic [IDX_W-1:0] block_idx_d, block_idx_q;
  logic             done_d, done_q;
  logic             cnt_load;
  logic [3:0]       cnt_load_val;
  logic             cnt_en;
  logic [3:0]       round;
  logic             last_round;

  ascon_round_counter u_round_counter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .round_o    (round)
  );

  assign last_round = (round == ROUND_LAST);

  // Handshake states are Mealy: the transfer cycle already performs the first round.
  always_comb begin
    state_d             = state_q;
    block_idx_d         = block_idx_q;
    done_d              = 1'b0;
    cnt_load            = 1'b0;
    cnt_load_val        = ROUND_A_START;
    cnt_en              = 1'b0;
    data_ready_o        = 1'b0;
    init_state_o        = 1'b0;
    en_reg_state_o      = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = INIT;
          cnt_load     = 1'b1;
          cnt_load_val = ROUND_A_START;
          block_idx_d  = '0;
        end
      end
      INIT: begin
        en_reg_state_o = 1'b1;
        init_state_o   = (round == ROUND_A_START);
        cnt_en         = 1'b1;
        if (last_round) begin
          en_xor_key_end_o = 1'b1;
          state_d          = WAIT_AD;
          cnt_load         = 1'b1;
          cnt_load_val     = ROUND_B_START;
        end
      end
      WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_state_o      = 1'b1;
          en_xor_data_begin_o = 1'b1;
          cnt_en              = 1'b1;
          state_d             = AD;
        end
      end
      AD: begin
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (last_round) begin
          en_xor_lsb_end_o = 1'b1;
          cnt_load         = 1'b1;
          if (NB_PT_BLOCKS == 1) begin
            state_d      = WAIT_FIN;
            cnt_load_val = ROUND_A_START;
          end else begin
            state_d      = WAIT_PT;
            cnt_load_val = ROUND_B_START;
          end
        end
      end
      WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_state_o      = 1'b1;
          en_xor_data_begin_o = 1'b1;
          en_cipher_o         = 1'b1;
          cnt_en              = 1'b1;
          block_idx_d         = block_idx_q + IDX_W'(1);
          state_d             = PT;
        end
      end
      PT: begin
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (last_round) begin
          cnt_load = 1'b1;
          if (block_idx_q < LAST_PT_IDX) begin
            state_d      = WAIT_PT;
            cnt_load_val = ROUND_B_START;
          end else begin
            state_d      = WAIT_FIN;
            cnt_load_val = ROUND_A_START;
          end
        end
      end
      WAIT_FIN: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_state_o      = 1'b1;
          en_xor_data_begin_o = 1'b1;
          en_xor_key_begin_o  = 1'b1;
          en_cipher_o         = 1'b1;
          cnt_en              = 1'b1;
          block_idx_d         = block_idx_q + IDX_W'(1);
          state_d             = FINAL;
        end
      end
      FINAL: begin
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (last_round) begin
          en_xor_key_end_o = 1'b1;
          en_tag_o         = 1'b1;
          done_d           = 1'b1;
          state_d          = IDLE;
          cnt_load         = 1'b1;
          cnt_load_val     = ROUND_A_START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      block_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_idx_q <= block_idx_d;
      done_q      <= done_d;
    end
  end

  assign round_o     = round;
  assign block_idx_o = block_idx_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: doc/ascon_fsm.md
# ascon_fsm

Control FSM for the ASCON-128 encryption core. It sequences the shared permutation datapath: the XOR-begin stage, the round function, the XOR-end stage and the state register. The sequence is initialisation, one associated-data block, `NB_PT_BLOCKS` plaintext blocks and finalisation. The datapath runs one round per cycle, and this block issues every enable, the round constant index and the data handshake.

## Interface
- `NB_PT_BLOCKS`, default 4: plaintext blocks per message; legal range ≥1.
- `clock_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `start_i` in 1: start a message; sampled only in `IDLE`.
- `data_valid_i` in 1: 64-bit AD/PT block is present on the datapath `data_i`.
- `data_ready_o` out 1: FSM can accept a block.
- `init_state_o` out 1: state register mux selects IV‖K‖N.
- `en_reg_state_o` out 1: state register load.
- `round_o` out 4: round index 0..11 driven to the constant adder.
- `en_xor_data_begin_o` out 1: XOR `data_i` into x0 before the round.
- `en_xor_key_begin_o` out 1: XOR K into x1‖x2 before the round.
- `en_xor_key_end_o` out 1: XOR 0‖K into x3‖x4 after the round.
- `en_xor_lsb_end_o` out 1: XOR 1 into LSB of x4 after the round (domain separation).
- `en_cipher_o` out 1: capture ciphertext block.
- `en_tag_o` out 1: capture tag.
- `block_idx_o` out `$clog2(NB_PT_BLOCKS+1)`: PT blocks accepted so far.
- `busy_o` out 1: high in any state except `IDLE`.
- `done_o` out 1: one-cycle end-of-message pulse.

## Operation
- States: `IDLE`, `INIT`, `WAIT_AD`, `AD`, `WAIT_PT`, `PT`, `WAIT_FIN`, `FINAL`.
- **IDLE**
  - `start_i=1` → `INIT`; round counter loads 0.
  - All other inputs are ignored.
- **INIT**
  - Rounds 0..11; `en_reg_state_o=1` every cycle.
  - `init_state_o=1` only at round 0.
  - At round 11: `en_xor_key_end_o=1`, then go to `WAIT_AD`.
- **WAIT\_\* states (handshake)**
  - `data_ready_o=1` in these states only.
  - A transfer happens in the cycle where `data_valid_i & data_ready_o`.
  - The transfer cycle is also the first round: outputs are Mealy, from state + `data_valid_i`.
  - On transfer: `en_reg_state_o=1` and `en_xor_data_begin_o=1`.
  - Without `data_valid_i`, all enables are 0 and the counter holds.
- **WAIT_AD → AD**
  - Transfer cycle is round 6; `AD` covers rounds 7..11.
  - At round 11: `en_xor_lsb_end_o=1`, then go to `WAIT_PT`.
- **WAIT_PT → PT** (non-final blocks)
  - Transfer cycle is round 6 with `en_cipher_o=1`; `block_idx_o` increments.
  - `PT` covers rounds 7..11.
  - At round 11: go to `WAIT_PT` if `block_idx_o < NB_PT_BLOCKS-1`, else to `WAIT_FIN`.
  - If `NB_PT_BLOCKS=1`, `AD` exits directly to `WAIT_FIN`.
- **WAIT_FIN → FINAL**
  - Transfer cycle is round 0 with `en_xor_data_begin_o`, `en_xor_key_begin_o` and `en_cipher_o` all =1; `block_idx_o` increments.
  - `FINAL` covers rounds 1..11.
  - At round 11: `en_xor_key_end_o=1` and `en_tag_o=1`, then go to `IDLE`.
- **done_o** is registered; it is high in the first `IDLE` cycle after `FINAL`. A `start_i` in that cycle is accepted.
- **Counter**
  - Loads 0 for `INIT`/`FINAL` and 6 for AD/PT blocks.
  - Increments by 1 per round cycle and never wraps past 11.
  - Round 11 is the exit condition.
- **Resets and interruptions**
  - `block_idx_o` clears on `start_i` acceptance.
  - `reset_i` in any state, including mid-round: the next edge forces `IDLE`, with counter=0, `block_idx_o`=0 and `done_o`=0.
  - There is no resume after a reset.
  - `start_i` while busy has no effect.

## Timing
- Reset values: every output is 0.
- `round_o` is 0 and `data_ready_o` is 0 (`IDLE` holds no ready).
- Cycle budget with `data_valid_i` held high:
  - `INIT`: 12 cycles.
  - AD block and each non-final PT block: 6 cycles, counted from the transfer cycle.
  - `FINAL`: 12 cycles.
- Total from `start_i` edge to `done_o` = 1 + 12 + 6·NB_PT_BLOCKS + 12 cycles, i.e. 49 for NB_PT_BLOCKS=4.
- Each `WAIT` cycle without `data_valid_i` adds exactly one cycle.
- At most one transfer per block; `data_ready_o` drops the cycle after a transfer.

## Structure
- Shared package `ascon_pack` holds:
  - `type_fsm_state` enum;
  - constants `ROUND_A_START=4'd0`, `ROUND_B_START=4'd6`, `ROUND_LAST=4'd11`.
- Sub-module `ascon_round_counter`: 4-bit counter with `load_i`, `load_val_i`, `en_i`, synchronous active-high reset, and output `round_o`.
- FSM: a registered state block plus one combinational next-state/output block.

## Test plan
- Reset mid-`INIT` at round 5 → next cycle `IDLE`; all outputs 0; `round_o`=0.
- `start_i` at cycle 0 with valid held high and NB_PT_BLOCKS=4 → check:
  - `init_state_o` at cycle 1;
  - `en_xor_key_end_o` at cycle 12;
  - transfers at cycles 13, 19, 25, 31, 37;
  - `en_xor_lsb_end_o` at cycle 18;
  - `en_tag_o` at cycle 48;
  - `done_o` at cycle 49.
- Valid low for 3 cycles in `WAIT_AD` → everything after shifts by 3; no enables and `round_o` frozen while waiting.
- NB_PT_BLOCKS=1 → `AD` goes directly to `WAIT_FIN`; `done_o` at cycle 31.
- `start_i` pulsed in `PT` → ignored; `block_idx_o` sequence is 1, 2, 3, 4 only.
- Back-to-back: `start_i` in the `done_o` cycle → `INIT` begins the next cycle and `block_idx_o` clears.
